// File: rtl/apb_master_bridge.sv
// Single-outstanding request/response to APB master bridge.
// One transfer at a time: IDLE -> SETUP -> ACCESS (with wait states / timeout) -> RESP.
module apb_master_bridge #(
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  req_write,
    input  logic [DATA_WIDTH-1:0] req_wdata,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,

    output logic [ADDR_WIDTH-1:0] paddr,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    localparam int unsigned CNT_W = 8;
    // Counter holds ACCESS cycles already completed, so the last allowed cycle sees TIMEOUT_CYCLES-1.
    localparam logic [CNT_W-1:0] LAST_ACCESS = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_nxt;

    logic [ADDR_WIDTH-1:0] paddr_nxt;
    logic                  psel_nxt;
    logic                  penable_nxt;
    logic                  pwrite_nxt;
    logic [DATA_WIDTH-1:0] pwdata_nxt;
    logic                  rsp_valid_nxt;
    logic [DATA_WIDTH-1:0] rsp_rdata_nxt;
    logic                  rsp_err_nxt;
    logic                  rsp_timeout_nxt;

    // State and access counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Registered APB and response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            paddr       <= '0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            pwdata      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            paddr       <= paddr_nxt;
            psel        <= psel_nxt;
            penable     <= penable_nxt;
            pwrite      <= pwrite_nxt;
            pwdata      <= pwdata_nxt;
            rsp_valid   <= rsp_valid_nxt;
            rsp_rdata   <= rsp_rdata_nxt;
            rsp_err     <= rsp_err_nxt;
            rsp_timeout <= rsp_timeout_nxt;
        end
    end

    // Next-state and next-output logic; every register holds unless a transition updates it
    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        paddr_nxt       = paddr;
        psel_nxt        = psel;
        penable_nxt     = penable;
        pwrite_nxt      = pwrite;
        pwdata_nxt      = pwdata;
        rsp_valid_nxt   = rsp_valid;
        rsp_rdata_nxt   = rsp_rdata;
        rsp_err_nxt     = rsp_err;
        rsp_timeout_nxt = rsp_timeout;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_nxt   = SETUP;
                    cnt_nxt     = '0;
                    paddr_nxt   = req_addr;
                    pwrite_nxt  = req_write;
                    pwdata_nxt  = req_wdata;
                    psel_nxt    = 1'b1;
                    penable_nxt = 1'b0;
                end
            end

            SETUP: begin
                state_nxt   = ACCESS;
                penable_nxt = 1'b1;
            end

            ACCESS: begin
                if (pready) begin
                    state_nxt       = RESP;
                    psel_nxt        = 1'b0;
                    penable_nxt     = 1'b0;
                    rsp_valid_nxt   = 1'b1;
                    rsp_rdata_nxt   = pwrite ? '0 : prdata;
                    rsp_err_nxt     = pslverr;
                    rsp_timeout_nxt = 1'b0;
                end else if (cnt == LAST_ACCESS) begin
                    // Abort: pslverr is deliberately ignored, a timeout is always an error
                    state_nxt       = RESP;
                    psel_nxt        = 1'b0;
                    penable_nxt     = 1'b0;
                    rsp_valid_nxt   = 1'b1;
                    rsp_rdata_nxt   = '0;
                    rsp_err_nxt     = 1'b1;
                    rsp_timeout_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            RESP: begin
                if (rsp_ready) begin
                    state_nxt     = IDLE;
                    rsp_valid_nxt = 1'b0;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign req_ready = (state == IDLE);

endmodule
